// File: rtl/types.sv
// Router-wide shared types.
// flit_t : one flit as carried on every router channel.
package types;

  typedef struct packed {
    logic [3:0] dest;
    logic [3:0] seq;
    logic [7:0] payload;
  } flit_t;

endpackage

// File: rtl/router_output_arbiter.sv
// Wormhole output-port arbiter: round-robin grant on head flits, then the
// output stays locked to the winner until that packet's tail flit transfers.
//
// Optional feature macro: ROUTER_ARB_WATCHDOG_EN (stall watchdog, sticky flag).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_in_valid      per-input flit valid
//   i_in_flit       per-input flit
//   i_in_is_head    per-input head-flit marker
//   i_in_is_tail    per-input tail-flit marker (head+tail = single-flit packet)
//   o_in_ready      per-input accept (only the owner can see out_ready)
//   o_out_valid     forwarded flit valid
//   o_out_flit      forwarded flit (0 while idle)
//   i_out_ready     downstream accept
//   o_grant         one-hot current owner, 0 when idle
//   o_busy          output locked to a packet
//   o_stall_error   sticky watchdog flag (0 when the watchdog is not built)
module router_output_arbiter #(
  parameter int unsigned NUM_INPUTS  = 5,
  parameter int unsigned FLIT_WIDTH  = $bits(types::flit_t),
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic        [NUM_INPUTS-1:0]   i_in_valid,
  input  types::flit_t [NUM_INPUTS-1:0]  i_in_flit,
  input  logic        [NUM_INPUTS-1:0]   i_in_is_head,
  input  logic        [NUM_INPUTS-1:0]   i_in_is_tail,
  output logic        [NUM_INPUTS-1:0]   o_in_ready,
  output logic                           o_out_valid,
  output logic        [FLIT_WIDTH-1:0]   o_out_flit,
  input  logic                           i_out_ready,
  output logic        [NUM_INPUTS-1:0]   o_grant,
  output logic                           o_busy,
  output logic                           o_stall_error
);

  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_INPUTS-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]        r_owner, w_owner_nxt;
  logic [IDX_W-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_INPUTS-1:0]   w_cand;
  logic                    w_found;
  logic [IDX_W-1:0]        w_winner;
  int unsigned             w_idx;
  logic                    w_xfer;

  // Only head flits may open a packet.
  assign w_cand = i_in_valid & i_in_is_head;

  // First candidate at or after rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NUM_INPUTS;
      if (!w_found && w_cand[IDX_W'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next state and datapath steering.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    o_in_ready   = '0;
    o_out_valid  = 1'b0;
    o_out_flit   = '0;
    w_xfer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LOCKED;
          w_owner_nxt = w_winner;
          w_grant_nxt = NUM_INPUTS'(1) << w_winner;
        end
      end
      S_LOCKED: begin
        o_out_valid         = i_in_valid[r_owner];
        o_out_flit          = FLIT_WIDTH'(i_in_flit[r_owner]);
        o_in_ready[r_owner] = i_out_ready;
        w_xfer              = i_in_valid[r_owner] & i_out_ready;
        // Tail transfer releases the lock; the released owner goes last next time.
        if (w_xfer && i_in_is_tail[r_owner]) begin
          w_state_nxt  = S_IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = (r_owner == IDX_W'(NUM_INPUTS - 1)) ? '0 : r_owner + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state == S_LOCKED);

`ifdef ROUTER_ARB_WATCHDOG_EN
  logic [7:0] r_stall_cnt, w_stall_cnt_nxt;
  logic       r_stall_error;

  // Consecutive locked cycles without a transfer, saturating.
  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if ((r_state != S_LOCKED) || w_xfer) begin
      w_stall_cnt_nxt = '0;
    end else if (r_stall_cnt != 8'hFF) begin
      w_stall_cnt_nxt = r_stall_cnt + 8'd1;
    end
  end

  // Flag is sticky until reset and never touches the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_stall_error <= 1'b0;
    end else begin
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_stall_error <= r_stall_error | (w_stall_cnt_nxt == 8'(STALL_LIMIT));
    end
  end

  assign o_stall_error = r_stall_error;
`else
  // No watchdog built; the term keeps the threshold parameter referenced.
  assign o_stall_error = 1'b0 & (STALL_LIMIT != 0);
`endif

endmodule
